// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM arbiter: load/store access sizes, arbiter state
// and response-owner encodings.
package LOAD_STORE_FNS;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } funct3_t;

endpackage

package MEM_ARB_PKG;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_LS   = 2'b10
  } rsp_owner_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// starve_counter: saturating counter with synchronous clear and an at-max flag,
// used to bound how long instruction fetch can lose arbitration.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] count;

  // Clear wins over increment; holds once MAX is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX))) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: boot-loader, fetch and load/store sharing of the single-port RAM.
// Define MEM_ARBITER_FAIRNESS_EN to let a starved fetch override load/store priority.
module mem_arbiter
  import MEM_ARB_PKG::*;
  import LOAD_STORE_FNS::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_BITS  = 11,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot_valid,
  output logic                 boot_ready,
  input  logic [ADDR_BITS-1:0] boot_addr,
  input  logic [WIDTH-1:0]     boot_data,
  input  logic                 boot_done,
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [WIDTH-1:0]     if_addr,
  output logic                 if_rsp_valid,
  output logic [WIDTH-1:0]     if_rsp_data,
  input  logic                 ls_req_valid,
  output logic                 ls_req_ready,
  input  logic [WIDTH-1:0]     ls_addr,
  input  logic                 ls_wren,
  input  logic [WIDTH-1:0]     ls_wr_data,
  input  funct3_t              ls_funct3,
  output logic                 ls_rsp_valid,
  output logic [WIDTH-1:0]     ls_rsp_data,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wren,
  output logic [WIDTH-1:0]     mem_wr_data,
  output funct3_t              mem_funct3,
  input  logic [WIDTH-1:0]     mem_rd_data
);

  arb_state_t state;
  rsp_owner_t owner;
  logic       boot_acc;
  logic       if_acc;
  logic       ls_acc;
  logic       if_force;
  logic       if_win;
  logic       ls_win;
  logic       unused_addr_bits;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  assign unused_addr_bits = ^{if_addr[WIDTH-1:ADDR_BITS+2], if_addr[1:0],
                              ls_addr[WIDTH-1:ADDR_BITS+2], ls_addr[1:0]};

`ifdef MEM_ARBITER_FAIRNESS_EN
  logic starve_clr;
  logic starve_inc;

  assign starve_clr = !if_req_valid || if_acc;
  assign starve_inc = (state == RUN) && if_req_valid && !if_acc;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .at_max (if_force)
  );
`else
  assign if_force = 1'b0;
`endif

  assign ls_win = ls_req_valid && !(if_force && if_req_valid);
  assign if_win = if_req_valid && (!ls_req_valid || if_force);

  // Ready generation; everything is held off while reset is asserted.
  always_comb begin
    boot_ready   = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if (!rst) begin
      boot_ready = 1'b0;
    end else if (state == BOOT) begin
      boot_ready = 1'b1;
    end else if (ls_win) begin
      ls_req_ready = 1'b1;
    end else if (if_win) begin
      if_req_ready = 1'b1;
    end else begin
      ls_req_ready = 1'b0;
    end
  end

  assign boot_acc = boot_valid && boot_ready;
  assign ls_acc   = ls_req_valid && ls_req_ready;
  assign if_acc   = if_req_valid && if_req_ready;

  // RAM port mux driven by whichever requester was accepted this cycle.
  always_comb begin
    mem_addr    = '0;
    mem_wren    = 1'b0;
    mem_wr_data = '0;
    mem_funct3  = WORD;
    if (boot_acc) begin
      mem_addr    = boot_addr;
      mem_wren    = 1'b1;
      mem_wr_data = boot_data;
    end else if (ls_acc) begin
      mem_addr    = ls_addr[ADDR_BITS+1:2];
      mem_wren    = ls_wren;
      mem_wr_data = ls_wr_data;
      mem_funct3  = ls_funct3;
    end else if (if_acc) begin
      mem_addr    = if_addr[ADDR_BITS+1:2];
    end else begin
      mem_wren    = 1'b0;
    end
  end

  // BOOT -> RUN once the loader signals completion; RUN holds until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else if ((state == BOOT) && boot_done) begin
      state <= RUN;
    end else begin
      state <= state;
    end
  end

  // Remembers who owns next cycle's RAM read data; stores and boot writes own nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_NONE;
    end else if (if_acc) begin
      owner <= OWN_IF;
    end else if (ls_acc && !ls_wren) begin
      owner <= OWN_LS;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign if_rsp_valid = (owner == OWN_IF);
  assign ls_rsp_valid = (owner == OWN_LS);
  assign if_rsp_data  = if_rsp_valid ? mem_rd_data : '0;
  assign ls_rsp_data  = ls_rsp_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency RAM model behind it.
module tb_mem_arbiter;
  import LOAD_STORE_FNS::*;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 11;
`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 boot_valid;
  logic                 boot_ready;
  logic [ADDR_BITS-1:0] boot_addr;
  logic [WIDTH-1:0]     boot_data;
  logic                 boot_done;
  logic                 if_req_valid;
  logic                 if_req_ready;
  logic [WIDTH-1:0]     if_addr;
  logic                 if_rsp_valid;
  logic [WIDTH-1:0]     if_rsp_data;
  logic                 ls_req_valid;
  logic                 ls_req_ready;
  logic [WIDTH-1:0]     ls_addr;
  logic                 ls_wren;
  logic [WIDTH-1:0]     ls_wr_data;
  funct3_t              ls_funct3;
  logic                 ls_rsp_valid;
  logic [WIDTH-1:0]     ls_rsp_data;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_wren;
  logic [WIDTH-1:0]     mem_wr_data;
  funct3_t              mem_funct3;
  logic [WIDTH-1:0]     mem_rd_data;

  logic [WIDTH-1:0] ram [0:(1<<ADDR_BITS)-1];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read of the current address.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  mem_arbiter #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_ready(boot_ready), .boot_addr(boot_addr),
    .boot_data(boot_data), .boot_done(boot_done),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wren(ls_wren), .ls_wr_data(ls_wr_data), .ls_funct3(ls_funct3),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wr_data(mem_wr_data),
    .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; boot_valid = 1'b1; boot_addr = 11'd1; boot_data = 32'h1111_1111; boot_done = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h0000_000C; ls_req_valid = 1'b1; ls_addr = 32'h0000_0014;
    ls_wren = 1'b0; ls_wr_data = 32'h0; ls_funct3 = WORD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (boot_ready !== 1'b0) begin bad++; $display("FAIL rst_boot_ready got=%0h want=0", boot_ready); end
    total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL rst_if_ready got=%0h want=0", if_req_ready); end
    total++; if (ls_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ls_ready got=%0h want=0", ls_req_ready); end
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL rst_mem_wren got=%0h want=0", mem_wren); end
    total++; if ({if_rsp_valid, ls_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%0b want=00", {if_rsp_valid, ls_rsp_valid}); end
    boot_valid = 1'b0; ls_req_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (boot_ready !== 1'b1) begin bad++; $display("FAIL boot_ready_after_rst got=%0h want=1", boot_ready); end
    total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL if_ready_in_boot got=%0h want=0", if_req_ready); end
    next_cycle();
  endtask

  task automatic test_boot();
    boot_valid = 1'b1; boot_addr = 11'd5; boot_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (mem_wren !== 1'b1) begin bad++; $display("FAIL boot_wren got=%0h want=1", mem_wren); end
    total++; if (mem_addr !== 11'd5) begin bad++; $display("FAIL boot_addr got=%0h want=5", mem_addr); end
    total++; if (mem_wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL boot_data got=%0h want=deadbeef", mem_wr_data); end
    total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL boot_if_ready got=%0h want=0", if_req_ready); end
    next_cycle();
    boot_addr = 11'd3; boot_data = 32'hA5A5_A5A5; boot_done = 1'b1;
    @(negedge clk);
    total++; if ({boot_ready, mem_wren, mem_addr} !== {1'b1, 1'b1, 11'd3}) begin bad++; $display("FAIL boot_done_write got=%0b/%0b/%0h want=1/1/3", boot_ready, mem_wren, mem_addr); end
    total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL boot_done_if_ready got=%0h want=0", if_req_ready); end
    next_cycle();
    boot_valid = 1'b0; boot_done = 1'b0;
    @(negedge clk);
    total++; if (boot_ready !== 1'b0) begin bad++; $display("FAIL run_boot_ready got=%0h want=0", boot_ready); end
    total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL run_if_ready got=%0h want=1", if_req_ready); end
    total++; if ({mem_wren, mem_addr, mem_funct3} !== {1'b0, 11'd3, WORD}) begin bad++; $display("FAIL if_mem_port got=%0b/%0h/%0h want=0/3/2", mem_wren, mem_addr, mem_funct3); end
    next_cycle();
    if_req_valid = 1'b0;
    @(negedge clk);
    total++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'hA5A5_A5A5}) begin bad++; $display("FAIL if_rsp got=%0b/%0h want=1/a5a5a5a5", if_rsp_valid, if_rsp_data); end
    next_cycle();
  endtask

  task automatic test_load_latency();
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0014; ls_wren = 1'b0; ls_funct3 = HALF;
    @(negedge clk);
    total++; if (ls_req_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%0h want=1", ls_req_ready); end
    total++; if ({mem_wren, mem_addr, mem_funct3} !== {1'b0, 11'd5, HALF}) begin bad++; $display("FAIL load_mem_port got=%0b/%0h/%0h want=0/5/1", mem_wren, mem_addr, mem_funct3); end
    next_cycle();
    ls_req_valid = 1'b0; ls_funct3 = WORD;
    @(negedge clk);
    total++; if ({ls_rsp_valid, ls_rsp_data} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL load_rsp got=%0b/%0h want=1/deadbeef", ls_rsp_valid, ls_rsp_data); end
    total++; if (if_rsp_valid !== 1'b0) begin bad++; $display("FAIL load_if_rsp got=%0h want=0", if_rsp_valid); end
    next_cycle();
    @(negedge clk);
    total++; if (ls_rsp_valid !== 1'b0) begin bad++; $display("FAIL load_rsp_once got=%0h want=0", ls_rsp_valid); end
    next_cycle();
  endtask

  task automatic test_contention();
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0014; ls_wren = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h0000_000C;
    @(negedge clk);
    total++; if ({ls_req_ready, if_req_ready} !== 2'b10) begin bad++; $display("FAIL cont_first got=%0b want=10", {ls_req_ready, if_req_ready}); end
    next_cycle();
    ls_req_valid = 1'b0;
    @(negedge clk);
    total++; if ({ls_req_ready, if_req_ready} !== 2'b01) begin bad++; $display("FAIL cont_second got=%0b want=01", {ls_req_ready, if_req_ready}); end
    total++; if ({ls_rsp_valid, if_rsp_valid, ls_rsp_data} !== {2'b10, 32'hDEAD_BEEF}) begin bad++; $display("FAIL cont_ls_rsp got=%0b%0b/%0h want=10/deadbeef", ls_rsp_valid, if_rsp_valid, ls_rsp_data); end
    next_cycle();
    if_req_valid = 1'b0;
    @(negedge clk);
    total++; if ({ls_rsp_valid, if_rsp_valid, if_rsp_data} !== {2'b01, 32'hA5A5_A5A5}) begin bad++; $display("FAIL cont_if_rsp got=%0b%0b/%0h want=01/a5a5a5a5", ls_rsp_valid, if_rsp_valid, if_rsp_data); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_if;
    logic prev_if;
    logic prev_ls;
    prev_if = 1'b0; prev_ls = 1'b0;
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0014; ls_wren = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h0000_000C;
    for (int c = 1; c <= 8; c++) begin
      exp_if = FAIR && (c == 5);
      @(negedge clk);
      total++; if ({if_req_ready, ls_req_ready} !== {exp_if, ~exp_if}) begin bad++; $display("FAIL starve_grant_c%0d got=%0b want=%0b", c, {if_req_ready, ls_req_ready}, {exp_if, ~exp_if}); end
      total++; if ({if_rsp_valid, ls_rsp_valid} !== {prev_if, prev_ls}) begin bad++; $display("FAIL starve_rsp_c%0d got=%0b want=%0b", c, {if_rsp_valid, ls_rsp_valid}, {prev_if, prev_ls}); end
      prev_if = exp_if; prev_ls = ~exp_if;
      next_cycle();
      if (prev_if) if_req_valid = 1'b0;
    end
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    @(negedge clk);
    total++; if ({if_rsp_valid, ls_rsp_valid} !== {prev_if, prev_ls}) begin bad++; $display("FAIL starve_tail got=%0b want=%0b", {if_rsp_valid, ls_rsp_valid}, {prev_if, prev_ls}); end
    next_cycle();
  endtask

  task automatic test_store_load();
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0020; ls_wren = 1'b1; ls_wr_data = 32'h1234_5678; ls_funct3 = WORD;
    @(negedge clk);
    total++; if ({ls_req_ready, mem_wren, mem_addr} !== {2'b11, 11'd8}) begin bad++; $display("FAIL store_port got=%0b%0b/%0h want=11/8", ls_req_ready, mem_wren, mem_addr); end
    total++; if (mem_wr_data !== 32'h1234_5678) begin bad++; $display("FAIL store_data got=%0h want=12345678", mem_wr_data); end
    next_cycle();
    ls_wren = 1'b0; ls_wr_data = 32'h0;
    @(negedge clk);
    total++; if (ls_rsp_valid !== 1'b0) begin bad++; $display("FAIL store_no_rsp got=%0h want=0", ls_rsp_valid); end
    total++; if ({ls_req_ready, mem_wren, mem_addr} !== {2'b10, 11'd8}) begin bad++; $display("FAIL reload_port got=%0b%0b/%0h want=10/8", ls_req_ready, mem_wren, mem_addr); end
    next_cycle();
    ls_req_valid = 1'b0;
    @(negedge clk);
    total++; if ({ls_rsp_valid, ls_rsp_data} !== {1'b1, 32'h1234_5678}) begin bad++; $display("FAIL reload_rsp got=%0b/%0h want=1/12345678", ls_rsp_valid, ls_rsp_data); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    if_req_valid = 1'b1; if_addr = 32'h0000_000C;
    @(negedge clk);
    total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL mid_if_ready got=%0h want=1", if_req_ready); end
    next_cycle();
    total++; if (if_rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_if_rsp_before got=%0h want=1", if_rsp_valid); end
    rst = 1'b0;
    #1;
    total++; if ({if_rsp_valid, if_req_ready, mem_wren} !== 3'b000) begin bad++; $display("FAIL mid_rst_drop got=%0b want=000", {if_rsp_valid, if_req_ready, mem_wren}); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if ({boot_ready, if_req_ready} !== 2'b10) begin bad++; $display("FAIL mid_back_to_boot got=%0b want=10", {boot_ready, if_req_ready}); end
    if_req_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_load_latency();
    test_contention();
    test_starvation();
    test_store_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single-port data/instruction RAM between three requesters: the boot flash loader, instruction fetch (IF) and load/store (LS). After reset it serves only the boot loader. Once boot completes it arbitrates IF and LS every cycle, with LS priority and an optional anti-starvation rule for IF. It sits between the core's fetch and memory stages and the `memory` block's RAM port, and returns read data with the RAM's one-cycle latency.

## Interface
- WIDTH, 32, data and byte-address width
- ADDR_BITS, 11, RAM word-address width
- STARVE_MAX, 4, consecutive IF stall cycles before IF is forced to win
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- boot_valid  in  1  boot write request
- boot_ready  out  1  boot write accepted
- boot_addr  in  ADDR_BITS  boot word address
- boot_data  in  WIDTH  boot write data
- boot_done  in  1  boot loader finished
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch accepted
- if_addr  in  WIDTH  fetch byte address
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  WIDTH  fetched word
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted
- ls_addr  in  WIDTH  byte address
- ls_wren  in  1  0 = load, 1 = store
- ls_wr_data  in  WIDTH  store data
- ls_funct3  in  funct3_t  access size
- ls_rsp_valid  out  1  load data valid; never asserted for stores
- ls_rsp_data  out  WIDTH  load word
- mem_addr  out  ADDR_BITS  RAM word address
- mem_wren  out  1  RAM write enable
- mem_wr_data  out  WIDTH  RAM write data
- mem_funct3  out  funct3_t  size passed to RAM
- mem_rd_data  in  WIDTH  RAM read data, valid one cycle after the address

## Operation
- FSM states: BOOT (reset state) and RUN.
- BOOT -> RUN when boot_done is high at a clock edge. RUN is terminal until reset.
- A transaction is accepted on any cycle where valid && ready. The requester holds valid and its payload stable until it is accepted.
- In BOOT:
  - boot_ready = 1, and the IF and LS readies are 0.
  - An accepted boot request drives mem_addr = boot_addr, mem_wr_data = boot_data, mem_wren = 1.
- In RUN:
  - boot_ready = 0.
  - If LS is valid, LS is granted; otherwise IF is granted if valid.
  - Exactly one ready is high, and only for a valid requester.
- Address mapping for IF and LS: mem_addr = addr[ADDR_BITS+1:2]. The low two address bits are not interpreted here.
- An accepted LS access drives mem_wren = ls_wren, mem_wr_data = ls_wr_data and mem_funct3 = ls_funct3.
- An accepted IF access drives mem_wren = 0 and mem_funct3 = WORD.
- With no acceptance in a cycle, mem_wren = 0 and the other mem outputs are don't-care.
- Response owner register: set to IF on an IF accept, to LS on an LS load accept, and to NONE otherwise.
  - The next cycle, the owner's rsp_valid = 1 and its rsp_data = mem_rd_data.
  - Responses have no backpressure; consumers must take them.
- Simultaneous boot_valid and boot_done: the write is accepted and RUN takes effect the next cycle.
- While rst is low, every ready, mem_wren and rsp_valid is forced to 0. A pending response is dropped.

## Timing
- Reset values: state BOOT, owner NONE, starvation counter 0, all rsp_valid 0, all ready 0, mem_wren 0.
- Request/response timing:
  - Ready and the mem_* outputs are combinational from the valids and the state.
  - A request accepted in cycle N produces its response in cycle N+1.
- Throughput is one access per cycle; back-to-back accepts pipeline with no bubble.
- A store accepted in cycle N is visible to a load accepted in cycle N+1.

## Configuration
- Macro: MEM_ARBITER_FAIRNESS_EN.
- Defined:
  - In RUN, a counter increments each cycle if_req_valid is high and IF is not accepted.
  - It clears on an IF accept or when if_req_valid is low, and saturates at STARVE_MAX.
  - When counter == STARVE_MAX, IF wins over LS for that cycle.
- Undefined: strict LS priority, no counter; IF may starve indefinitely.

## Structure
- Shared package `MEM_ARB_PKG`:
  - arb_state_t {BOOT, RUN}
  - rsp_owner_t {OWN_NONE, OWN_IF, OWN_LS}
- funct3_t and WORD are taken from LOAD_STORE_FNS.
- One natural sub-module: `starve_counter`, a saturating counter with clear and increment inputs and an at-max output. It is instantiated only under MEM_ARBITER_FAIRNESS_EN.

## Test plan
- Boot phase:
  - Stimulus: reset, then boot writes 0xDEADBEEF to word 5, with if_req_valid = 1 throughout.
  - Required: mem_wren = 1 with mem_addr = 5; if_req_ready stays 0 until the cycle after boot_done.
- Load latency:
  - Stimulus: RUN, LS load of address 0x14 with the RAM returning 0xDEADBEEF.
  - Required: ls_rsp_valid = 1 exactly one cycle later with ls_rsp_data = 0xDEADBEEF; if_rsp_valid = 0.
- Contention:
  - Stimulus: IF and LS both valid in the same cycle.
  - Required: LS accepted first, IF accepted the next cycle; responses arrive on consecutive cycles to the correct owners.
- Starvation (macro defined, STARVE_MAX = 4):
  - Stimulus: LS valid continuously and IF valid.
  - Required: IF accepted in the 5th cycle. With the macro undefined, IF is never accepted.
- Store then load:
  - Stimulus: LS store of 0x12345678 to 0x20, then a load of 0x20 in the next cycle.
  - Required: the store produces no ls_rsp_valid; the load returns 0x12345678.
- Reset mid-operation:
  - Stimulus: assert rst in the cycle after an IF accept.
  - Required: if_rsp_valid drops to 0 immediately; the state returns to BOOT.
